uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register in front of the shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
   parameter int CLKS_PER_BIT = 50
) (
   input  logic       i_Clock,
   input  logic       reset_n,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Ready,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done,
   output logic [2:0] o_Tx_State
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t      state_q;
   logic [7:0]  hold_q, hold_d;
   logic        full_q, full_d;
   logic        ready_q;
   logic [7:0]  shift_q;
   logic [15:0] cnt_q;
   logic [2:0]  idx_q;
   logic [2:0]  idx_nxt;
   logic        active_q, serial_q, done_q;
   logic        bit_end;
   logic        drain;

   // Handshake: i_Tx_DV is a write strobe qualified by o_Tx_Ready. A byte transfers on any
   // rising edge where both are 1; a strobe while o_Tx_Ready=0 is dropped without effect.
   assign bit_end = (cnt_q == LAST_CNT);
   assign idx_nxt = idx_q + 3'd1;
   assign drain   = full_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

   // The drain and an accepted write never coincide: draining implies full, hence not ready.
   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      if (drain) begin
         full_d = 1'b0;
      end else if (i_Tx_DV && ready_q) begin
         full_d = 1'b1;
         hold_d = i_Tx_Byte;
      end
   end

   always_ff @(posedge i_Clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q  <= 8'd0;
         full_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         hold_q  <= hold_d;
         full_q  <= full_d;
         ready_q <= !full_d;
      end
   end

   always_ff @(posedge i_Clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         shift_q  <= 8'd0;
         cnt_q    <= 16'd0;
         idx_q    <= 3'd0;
         active_q <= 1'b0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q    <= 16'd0;
               serial_q <= 1'b1;
               active_q <= 1'b0;
               if (full_q) begin
                  shift_q  <= hold_q;
                  serial_q <= 1'b0;
                  active_q <= 1'b1;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  cnt_q    <= 16'd0;
                  idx_q    <= 3'd0;
                  serial_q <= shift_q[0];
                  state_q  <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt_q <= 16'd0;
                  if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     serial_q <= ^shift_q;
                     state_q  <= S_PARITY;
`else
                     serial_q <= 1'b1;
                     state_q  <= S_STOP;
`endif
                  end else begin
                     idx_q    <= idx_nxt;
                     serial_q <= shift_q[idx_nxt];
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  cnt_q    <= 16'd0;
                  serial_q <= 1'b1;
                  state_q  <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  cnt_q  <= 16'd0;
                  done_q <= 1'b1;
                  // A queued byte starts its start bit right away so streaming has no gap.
                  if (full_q) begin
                     shift_q  <= hold_q;
                     serial_q <= 1'b0;
                     state_q  <= S_START;
                  end else begin
                     serial_q <= 1'b1;
                     active_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               cnt_q    <= 16'd0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign o_Tx_Ready  = ready_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Done   = done_q;
   assign o_Tx_State  = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with CLKS_PER_BIT=4 (vector table, corner sequences, random stream).
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME_CYC = FB * CPB;
   localparam int NV = 7;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       dv    = 1'b0;
   logic [7:0] din   = 8'd0;
   logic       o_rdy, o_act, o_ser, o_done;
   logic [2:0] o_state;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_seq;   // start, d0..d7, stop in time order, MSB first on the wire
      logic       exp_par;
   } vec_t;
   vec_t vecs[NV];

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock    (clk),
      .reset_n    (rst_n),
      .i_Tx_DV    (dv),
      .i_Tx_Byte  (din),
      .o_Tx_Ready (o_rdy),
      .o_Tx_Active(o_act),
      .o_Tx_Serial(o_ser),
      .o_Tx_Done  (o_done),
      .o_Tx_State (o_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: frames are time windows. A frame occupies FRAME_CYC cycles after the
   // edge it starts on; bit k of the frame is on the line during cycles [k*CPB, (k+1)*CPB).
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   int         cyc     = 0;
   int         m_start = 0;
   logic       m_busy  = 1'b0;
   logic       m_full  = 1'b0;
   logic       m_done  = 1'b0;
   logic       was_full;
   logic [7:0] m_hold  = 8'd0;
   logic [7:0] m_byte  = 8'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_full = 1'b0;
         m_done = 1'b0;
         exp_q.delete();
      end else begin
         cyc++;
         m_done   = 1'b0;
         was_full = m_full;
         if (m_busy && (cyc == m_start + FRAME_CYC)) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
         if (!m_busy && m_full) begin
            m_busy  = 1'b1;
            m_start = cyc;
            m_byte  = m_hold;
            m_full  = 1'b0;
         end
         if (dv && !was_full) begin
            m_full = 1'b1;
            m_hold = din;
            exp_q.push_back(din);
         end
      end
   end

   logic e_ser;
   always @(negedge clk) begin
      if (chk_en) begin
         e_ser = m_busy ? frame_bit(m_byte, (cyc - m_start) / CPB) : 1'b1;
         check("cycle_outputs", {28'd0, o_ser, o_act, o_rdy, o_done},
               {28'd0, e_ser, m_busy, !m_full, m_done});
      end
   end

   // Line decoder: samples mid-bit like a receiver and scores bytes against exp_q.
   logic          rx_busy = 1'b0;
   int            rx_t    = 0;
   logic [FB-1:0] rx_bits = '0;
   logic [7:0]    rx_byte;
   logic [7:0]    rx_exp;
   always @(negedge clk) begin
      if (!rst_n) begin
         rx_busy = 1'b0;
      end else begin
         if (!rx_busy) begin
            if (o_ser === 1'b0) begin
               rx_busy = 1'b1;
               rx_t    = 0;
            end
         end else begin
            rx_t++;
         end
         if (rx_busy && (rx_t % CPB == CPB / 2)) begin
            rx_bits[rx_t / CPB] = o_ser;
            if (rx_t / CPB == FB - 1) begin
               rx_busy = 1'b0;
               rx_byte = rx_bits[8:1];
               check("rx_start_bit", {31'd0, rx_bits[0]}, 32'd0);
               check("rx_stop_bit", {31'd0, rx_bits[FB-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
               check("rx_parity_bit", {31'd0, rx_bits[9]}, {31'd0, ^rx_byte});
`endif
               check("sb_frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  rx_exp = exp_q.pop_front();
                  check("sb_byte", {24'd0, rx_byte}, {24'd0, rx_exp});
               end
               rx_log.push_back(rx_byte);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((m_busy || m_full || rx_busy) && n < 4 * FRAME_CYC) begin
         tick();
         n++;
      end
      check("idle_timeout", {31'd0, n >= 4 * FRAME_CYC}, 32'd0);
      repeat (2) tick();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (o_rdy !== 1'b1 && n < 4 * FRAME_CYC) begin
         tick();
         n++;
      end
      check("ready_timeout", {31'd0, n >= 4 * FRAME_CYC}, 32'd0);
   endtask

   task automatic run_vec(input logic [7:0] b, output int fall_lat, output logic [FB-1:0] seq,
                          output int width_err, output int done_idx, output int done_cnt);
      dv  = 1'b1;
      din = b;
      tick();
      dv  = 1'b0;
      fall_lat = 1;
      while (o_ser === 1'b1 && fall_lat < 20) begin
         tick();
         fall_lat++;
      end
      seq = '0;
      width_err = 0;
      done_idx = -1;
      done_cnt = 0;
      for (int k = 0; k < FRAME_CYC + 3; k++) begin
         if (k < FRAME_CYC) begin
            if (k % CPB == 0) seq[FB-1-(k/CPB)] = o_ser;
            else if (o_ser !== seq[FB-1-(k/CPB)]) width_err++;
         end
         if (o_done === 1'b1) begin
            done_cnt++;
            if (done_idx < 0) done_idx = k;
         end
         tick();
      end
   endtask

   int            fall, werr, didx, dcnt, n_low, base;
   int            d_cnt, d0, d1, drop;
   logic          ser_at_d0;
   logic [FB-1:0] seq, exp_full;

   initial begin
      vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
      vecs[1] = '{8'h00, 10'b0000000001, 1'b0};
      vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
      vecs[3] = '{8'h01, 10'b0100000001, 1'b1};
      vecs[4] = '{8'h80, 10'b0000000011, 1'b1};
      vecs[5] = '{8'h3C, 10'b0001111001, 1'b0};
      vecs[6] = '{8'h07, 10'b0111000001, 1'b1};

      // Reset: hold 5 cycles, then idle with no writes.
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_serial", {31'd0, o_ser}, 32'd1);
      check("rst_ready", {31'd0, o_rdy}, 32'd1);
      check("rst_active", {31'd0, o_act}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_state", {29'd0, o_state}, 32'd0);
      rst_n = 1'b1;
      n_low = 0;
      repeat (10) begin
         tick();
         if (o_ser !== 1'b1) n_low++;
      end
      check("idle_line_high", n_low, 0);

      // A write on the first edge after reset release is accepted.
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      dv    = 1'b1;
      din   = 8'h3C;
      tick();
      dv    = 1'b0;
      check("first_write_after_release", {31'd0, o_rdy}, 32'd0);
      wait_idle();

      for (int i = 0; i < NV; i++) begin
         wait_idle();
         run_vec(vecs[i].data, fall, seq, werr, didx, dcnt);
`ifdef UART_TX_PARITY_EN
         exp_full = {vecs[i].exp_seq[9:1], vecs[i].exp_par, 1'b1};
`else
         exp_full = vecs[i].exp_seq;
`endif
         check($sformatf("v%0d_fall_latency", i), fall, 2);
         check($sformatf("v%0d_bits", i), 32'(seq), 32'(exp_full));
         check($sformatf("v%0d_bit_width", i), werr, 0);
         check($sformatf("v%0d_done_at", i), didx, FRAME_CYC);
         check($sformatf("v%0d_done_count", i), dcnt, 1);
      end

      // Back-to-back: second start bit directly follows the first stop bit.
      wait_idle();
      dv  = 1'b1;
      din = 8'h00;
      tick();
      dv  = 1'b0;
      n_low = 0;
      while (o_rdy !== 1'b1 && n_low < 20) begin
         tick();
         n_low++;
      end
      check("b2b_ready_return", n_low, 1);
      dv  = 1'b1;
      din = 8'hFF;
      tick();
      dv  = 1'b0;
      d_cnt = 0;
      d0 = -1;
      d1 = -1;
      drop = 0;
      ser_at_d0 = 1'b1;
      for (int t = 0; t < 2 * FRAME_CYC + 10; t++) begin
         if (o_done === 1'b1) begin
            d_cnt++;
            if (d0 < 0) begin
               d0 = t;
               ser_at_d0 = o_ser;
            end else if (d1 < 0) begin
               d1 = t;
            end
         end
         if (d1 < 0 && o_act !== 1'b1) drop++;
         tick();
      end
      check("b2b_done_count", d_cnt, 2);
      check("b2b_first_done", d0, FRAME_CYC - 1);
      check("b2b_done_spacing", d1 - d0, FRAME_CYC);
      check("b2b_no_gap", {31'd0, ser_at_d0}, 32'd0);
      check("b2b_active_held", drop, 0);

      // Overflow: third byte written while not ready is dropped.
      wait_idle();
      base = rx_log.size();
      dv  = 1'b1;
      din = 8'h11;
      tick();
      dv  = 1'b0;
      wait_ready();
      dv  = 1'b1;
      din = 8'h22;
      tick();
      dv  = 1'b0;
      check("ovf_ready_low", {31'd0, o_rdy}, 32'd0);
      dv  = 1'b1;
      din = 8'h33;
      tick();
      dv  = 1'b0;
      wait_idle();
      check("ovf_frame_count", rx_log.size() - base, 2);
      check("ovf_first_byte", {24'd0, rx_log[base]}, 32'h11);
      check("ovf_second_byte", {24'd0, rx_log[base+1]}, 32'h22);

      // Mid-frame reset during frame bit 3 (data bit 2 of 0x5A, a 0) with 0x77 queued.
      wait_idle();
      base = rx_log.size();
      dv  = 1'b1;
      din = 8'h5A;
      tick();
      dv  = 1'b0;
      tick();
      dv  = 1'b1;
      din = 8'h77;
      tick();
      dv  = 1'b0;
      repeat (3 * CPB) tick();
      check("mid_bit3_low", {31'd0, o_ser}, 32'd0);
      check("mid_holding_full", {31'd0, o_rdy}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_async_serial", {31'd0, o_ser}, 32'd1);
      check("mid_async_active", {31'd0, o_act}, 32'd0);
      check("mid_async_ready", {31'd0, o_rdy}, 32'd1);
      repeat (3) tick();
      rst_n = 1'b1;
      n_low = 0;
      repeat (3 * FRAME_CYC) begin
         tick();
         if (o_ser !== 1'b1) n_low++;
      end
      check("mid_line_stays_high", n_low, 0);
      check("mid_nothing_sent", rx_log.size() - base, 0);
      check("mid_ready_after", {31'd0, o_rdy}, 32'd1);

      // Random stream with quiet stretches.
      for (int c = 0; c < 1500; c++) begin
         if ((c / 250) % 2 == 1 && (c % 250) > 180) dv = 1'b0;
         else dv = ($urandom_range(0, 3) == 0);
         din = 8'($urandom_range(0, 255));
         tick();
      end
      dv = 1'b0;
      wait_idle();
      check("rand_scoreboard_drained", exp_q.size(), 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
